// File: rtl/satatrn_txmux.sv
// satatrn_txmux: round-robin FIS source mux with data-FIS header insertion
// and a per-FIS payload limit, behind a single registered output stage.
module satatrn_txmux #(
  parameter int NIN          = 3,
  parameter int DW           = 32,
  parameter int DATA_CHAN    = NIN - 1,
  parameter int LGMAXFIS     = 11,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_txgate,
  input  logic [NIN-1:0]         s_valid,
  output logic [NIN-1:0]         s_ready,
  input  logic [NIN-1:0]         s_last,
  input  logic [NIN*DW-1:0]      s_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic [DW-1:0]          o_data,
  output logic [$clog2(NIN)-1:0] o_chan,
  output logic                   o_busy
);
  localparam int CW = $clog2(NIN);
  localparam logic [DW-1:0] HDR_WORD = DW'(8'h46);
  localparam logic [LGMAXFIS:0] CNT_END =
    {1'b0, {LGMAXFIS{1'b1}}};

  typedef enum logic [1:0] {IDLE, HDR, PASS} state_t;

  state_t            state;
  logic [CW-1:0]     last_g;
  logic [CW-1:0]     pick;
  logic [CW-1:0]     cur;
  logic [LGMAXFIS:0] cnt;
  logic [NIN-1:0]    elig;
  logic              found;
  logic              slot_free;
  logic              grant;
  logic              is_data;
  logic              go;
  logic              accept;
  logic              beat_last;
  logic              load;
  logic              sel_v;
  logic              sel_l;
  logic [DW-1:0]     sel_d;
  logic [DW-1:0]     ld_data;
  logic              ld_last;
  int                best;
  int                off;

  // Rotate so the channel after the last grant has distance 0.
  always_comb begin
    elig  = '0;
    pick  = '0;
    found = 1'b0;
    best  = NIN;
    off   = 0;
    for (int k = 0; k < NIN; k++) begin
      elig[k] = s_valid[k] &&
                ((k != DATA_CHAN) || i_txgate);
      off = (k + NIN - 1 - int'(last_g)) % NIN;
      if (elig[k] && (off < best)) begin
        best  = off;
        pick  = CW'(k);
        found = 1'b1;
      end
    end
  end

  assign slot_free = !o_valid || i_ready;
  assign cur       = (state == IDLE) ? pick : o_chan;
  assign is_data   = (cur == CW'(DATA_CHAN));
  assign grant     = (state == IDLE) && found
                     && slot_free;

  always_comb begin
    sel_v = 1'b0;
    sel_l = 1'b0;
    sel_d = '0;
    for (int k = 0; k < NIN; k++) begin
      if (cur == CW'(k)) begin
        sel_v = s_valid[k];
        sel_l = s_last[k];
        sel_d = s_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    go = 1'b0;
    unique case (state)
      IDLE:    go = grant && !is_data;
      PASS:    go = slot_free;
      default: go = 1'b0;
    endcase
    s_ready = '0;
    for (int k = 0; k < NIN; k++)
      s_ready[k] = go && (cur == CW'(k));
  end

  assign accept    = go && sel_v;
  assign beat_last = sel_l ||
                     (is_data && (cnt == CNT_END));
  assign load      = accept ||
                     ((state == HDR) && slot_free);
  assign ld_data   = (state == HDR) ? HDR_WORD : sel_d;
  assign ld_last   = (state == HDR) ? 1'b0 : beat_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      last_g  <= CW'(NIN - 1);
      o_chan  <= '0;
      o_busy  <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            last_g <= pick;
            o_chan <= pick;
            if (is_data) begin
              state  <= HDR;
              o_busy <= 1'b1;
            end else if (!sel_l) begin
              state  <= PASS;
              o_busy <= 1'b1;
            end
          end
        end
        HDR: begin
          if (slot_free) begin
            cnt   <= '0;
            state <= PASS;
          end
        end
        PASS: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (beat_last) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        o_valid <= 1'b1;
        o_data  <= ld_data;
        o_last  <= ld_last;
      end else if (slot_free) begin
        o_valid <= 1'b0;
        if (OPT_LOWPOWER) begin
          o_data <= '0;
          o_last <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/satatrn_txmux.md
SATATRN_TXMUX -- requirements
Module: satatrn_txmux

Interface
REQ-001 SHALL have parameter NIN, default 3, meaning the number of FIS source channels (2..8).
REQ-002 SHALL have parameter DW, default 32, meaning the data word width (>= 8).
REQ-003 SHALL have parameter DATA_CHAN, default NIN-1, meaning the channel index that carries raw data-FIS payload.
REQ-004 SHALL have parameter LGMAXFIS, default 11, meaning log2 of the maximum payload words per data FIS.
REQ-005 SHALL have parameter OPT_LOWPOWER, default 1'b0, meaning o_data/o_last are zeroed whenever o_valid is low.
REQ-006 SHALL have port i_clk, input, 1, the single clock.
REQ-007 SHALL have port i_reset, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port i_txgate, input, 1, meaning the link permits a data FIS to start.
REQ-009 SHALL have ports s_valid / s_ready / s_last, input / output / input, NIN each, with one bit per channel.
REQ-010 SHALL have port s_data, input, NIN*DW, where channel k occupies bits [k*DW +: DW].
REQ-011 SHALL have ports o_valid / i_ready / o_last, output / input / output, 1 each, forming the outgoing stream.
REQ-012 SHALL have port o_data, output, DW, the outgoing FIS word.
REQ-013 SHALL have port o_chan, output, $clog2(NIN), meaning the channel currently granted (valid while o_busy).
REQ-014 SHALL have port o_busy, output, 1, meaning a grant is held.

Function
REQ-015 SHALL use a single registered output stage; a beat is accepted on channel k iff s_valid[k] && s_ready[k]; an output beat transfers iff o_valid && i_ready.
REQ-016 SHALL hold o_valid, o_data and o_last stable while o_valid && !i_ready.
REQ-017 SHALL implement states IDLE, HDR and PASS.
REQ-018 In IDLE, channel k SHALL be eligible iff s_valid[k], and additionally i_txgate when k == DATA_CHAN.
REQ-019 Arbitration SHALL be round-robin: the search starts at (last granted + 1) mod NIN and grants the first eligible channel.
REQ-020 The grant SHALL be made only when the output slot is free (!o_valid || i_ready).
REQ-021 Granting a non-data channel SHALL go to PASS with zero-cycle turnaround, forwarding its first beat in the same cycle.
REQ-022 Granting DATA_CHAN SHALL go to HDR; HDR SHALL load o_data = {(DW-8)'0, 8'h46}, o_last = 0, and SHALL assert no s_ready.
REQ-023 In HDR, when the output slot is free, the block SHALL load the header and go to PASS.
REQ-024 In PASS, s_ready[grant] SHALL equal (!o_valid || i_ready); all other s_ready bits SHALL be 0.
REQ-025 In PASS, each accepted beat SHALL be loaded into the output register next cycle, giving 1-cycle latency.
REQ-026 For non-data channels, o_last SHALL be s_last; on the accepted last beat the block SHALL return to IDLE and release the grant.
REQ-027 For DATA_CHAN, an LGMAXFIS+1-bit payload counter SHALL be cleared in HDR and incremented on each accepted beat.
REQ-028 For DATA_CHAN, o_last SHALL be s_last OR (counter == 2^LGMAXFIS - 1).
REQ-029 When a data FIS ends by count without s_last, the block SHALL go to IDLE, keep the data stream pending, and later emit a new header subject to i_txgate and round-robin.
REQ-030 Deassertion of i_txgate mid-FIS SHALL NOT interrupt the FIS; i_txgate SHALL be sampled only at grant.
REQ-031 Simultaneous grant-release and new grant SHALL NOT occur in the same cycle; IDLE always lasts at least one cycle after a last beat.
REQ-032 With OPT_LOWPOWER, the output register SHALL load zeros whenever it is free and no word is being loaded.

Reset
REQ-033 While i_reset is high, the block SHALL clear o_valid, o_last, o_data, o_busy, o_chan and the counter, set state to IDLE, and set the last-granted pointer to NIN-1 so that channel 0 is searched first.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; no partial-packet recovery is provided.

Verification
REQ-035 Bench: NIN=3; ch0 and ch1 both send 3-beat packets from reset -> ch0 packet first, then ch1; o_last on beats 3 and 6; s_ready[1]=0 throughout ch0.
REQ-036 Bench: i_txgate=0 with ch2 valid -> no grant to ch2; raise i_txgate -> output 0x00000046, then payload words.
REQ-037 Bench: LGMAXFIS=2, ch2 sends 6 words with s_last on word 6 -> header, 4 words (o_last on 4th), header, 2 words (o_last on 2nd).
REQ-038 Bench: random i_ready backpressure -> no dropped or duplicated words; o_data stable while stalled.
REQ-039 Bench: assert i_reset mid-packet -> o_valid=0 same cycle; after release, ch0 is granted first.
REQ-040 Bench: OPT_LOWPOWER=1 -> o_data==0 whenever o_valid==0.
